fma16_horner: RTL and testbench

Sequential polynomial evaluator that drives the combinational half-precision `fma16` unit as its initiator. It computes p(x) = c[d]·x^d + … + c[1]·x + c[0] by Horner's rule, issuing one fused multiply-add per clock. Results go out with sticky IEEE flags. It sits between a register-mapped coefficient store and the datapath, so firmware gets polynomial kernels such as reciprocal seeds and activation approximations with one rounding per step.

---
 rtl/fma16_horner_if.sv | 36 +++
 rtl/fma16_horner.sv | 134 +++++++++++++
 tb/tb_fma16_horner.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fma16_horner_if.sv
// Request/response bundle of the Horner polynomial evaluator: coefficient
// writes, evaluation requests and results.
interface fma16_horner_if #(
    parameter int DW = 3
);
    logic            coef_we;
    logic [DW-1:0]   coef_addr;
    logic [15:0]     coef_data;

    logic            start_valid;
    logic            start_ready;
    logic [15:0]     start_x;
    logic [DW-1:0]   start_deg;
    logic [1:0]      start_rm;

    logic            out_valid;
    logic            out_ready;
    logic [15:0]     out_result;
    logic [3:0]      out_flags;

    modport master (
        output coef_we, coef_addr, coef_data,
        output start_valid, start_x, start_deg, start_rm,
        input  start_ready,
        input  out_valid, out_result, out_flags,
        output out_ready
    );

    modport slave (
        input  coef_we, coef_addr, coef_data,
        input  start_valid, start_x, start_deg, start_rm,
        output start_ready,
        output out_valid, out_result, out_flags,
        input  out_ready
    );
endinterface

// File: rtl/fma16_horner.sv
// Horner-rule binary16 polynomial evaluator: one fused multiply-add per clock
// through an external combinational fma16, with sticky IEEE flags.
module fma16_horner #(
    parameter int N_COEF = 8,
    parameter int DW     = $clog2(N_COEF)
) (
    input  logic                clk,
    input  logic                rst_n,
    fma16_horner_if.slave       bus,
    output logic [15:0]         fma_x,
    output logic [15:0]         fma_y,
    output logic [15:0]         fma_z,
    output logic                fma_mul,
    output logic                fma_add,
    output logic                fma_negp,
    output logic                fma_negz,
    output logic [1:0]          fma_roundmode,
    input  logic [15:0]         fma_result,
    input  logic [3:0]          fma_flags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [15:0]     acc;
    logic [15:0]     x_r;
    logic [1:0]      rm_r;
    logic [DW-1:0]   cnt;
    logic [3:0]      flags_r;
    logic [15:0]     coef [N_COEF];

    logic [DW-1:0]   deg_eff;
    logic            start_acc;

    // Degrees beyond the storage depth evaluate the full stored polynomial.
    function automatic logic [DW-1:0] clamp_deg(input logic [DW-1:0] d);
        if (32'(d) >= N_COEF)
            return DW'(N_COEF - 1);
        return d;
    endfunction

    assign deg_eff   = clamp_deg(bus.start_deg);
    assign start_acc = (state == IDLE) && bus.start_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= 16'h0000;
            x_r     <= 16'h0000;
            rm_r    <= 2'b01;
            cnt     <= '0;
            flags_r <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        x_r     <= bus.start_x;
                        rm_r    <= bus.start_rm;
                        acc     <= coef[deg_eff];
                        cnt     <= deg_eff;
                        flags_r <= 4'b0000;
                    end
                end
                RUN: begin
                    acc     <= fma_result;
                    flags_r <= flags_r | fma_flags;
                    cnt     <= cnt - DW'(1);
                end
                default: ;
            endcase
        end
    end

    // Writes are frozen while an evaluation runs; an IDLE write lands after the start read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_COEF; i++)
                coef[i] <= 16'h0000;
        end else if (bus.coef_we && (state != RUN)) begin
            coef[bus.coef_addr] <= bus.coef_data;
        end
    end

    always_comb begin
        state_nxt       = state;
        bus.start_ready = 1'b0;
        bus.out_valid   = 1'b0;
        fma_x           = acc;
        fma_y           = 16'h3C00;
        fma_z           = 16'h0000;
        fma_mul         = 1'b0;
        fma_add         = 1'b0;
        fma_negp        = 1'b0;
        fma_negz        = 1'b0;
        fma_roundmode   = rm_r;
        case (state)
            IDLE: begin
                bus.start_ready = 1'b1;
                if (bus.start_valid)
                    state_nxt = (deg_eff == '0) ? DONE : RUN;
            end
            RUN: begin
                fma_y   = x_r;
                fma_z   = coef[cnt - DW'(1)];
                fma_mul = 1'b1;
                fma_add = 1'b1;
                if (cnt == DW'(1))
                    state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.out_result = (state == DONE) ? acc : 16'h0000;
    assign bus.out_flags  = (state == DONE) ? flags_r : 4'b0000;

endmodule

// File: tb/tb_fma16_horner.sv
// Bench for fma16_horner: behavioural binary16 FMA stands in for fma16, and a
// Horner reference over a shadow coefficient table predicts every result.
module tb_fma16_horner;
    localparam int N_COEF = 8;
    localparam int DW     = 3;

    logic        clk;
    logic        rst_n;
    logic [15:0] fma_x, fma_y, fma_z;
    logic        fma_mul, fma_add, fma_negp, fma_negz;
    logic [1:0]  fma_roundmode;
    logic [15:0] fma_result;
    logic [3:0]  fma_flags;

    int          n_cmp;
    int          n_bad;
    logic [15:0] shadow [N_COEF];

    fma16_horner_if #(.DW(DW)) bus ();

    fma16_horner #(.N_COEF(N_COEF), .DW(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .fma_x         (fma_x),
        .fma_y         (fma_y),
        .fma_z         (fma_z),
        .fma_mul       (fma_mul),
        .fma_add       (fma_add),
        .fma_negp      (fma_negp),
        .fma_negz      (fma_negz),
        .fma_roundmode (fma_roundmode),
        .fma_result    (fma_result),
        .fma_flags     (fma_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact a*b+c on integers scaled by 2^48, then one IEEE rounding; returns {result, flags}.
    function automatic logic [19:0] fma_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c, input logic [1:0] rm);
        logic a_nan, b_nan, c_nan, a_inf, b_inf, c_inf, a_zero, b_zero, snan, sp, sc, neg;
        logic inc, inexact, uf, to_inf;
        logic [127:0] ma, mb, mc, mag, tq, rem, half;
        logic signed [127:0] p, z, s;
        int sha, shb, shc, pos, sh, field;
        a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 0);
        b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 0);
        c_nan  = (c[14:10] == 5'h1F) && (c[9:0] != 0);
        a_inf  = (a[14:0] == 15'h7C00);
        b_inf  = (b[14:0] == 15'h7C00);
        c_inf  = (c[14:0] == 15'h7C00);
        a_zero = (a[14:0] == 15'h0000);
        b_zero = (b[14:0] == 15'h0000);
        sp = a[15] ^ b[15];
        sc = c[15];
        snan = (a_nan && !a[9]) || (b_nan && !b[9]) || (c_nan && !c[9]);
        if (a_nan || b_nan || c_nan) return {16'h7E00, snan, 3'b000};
        if ((a_inf && b_zero) || (b_inf && a_zero)) return {16'h7E00, 4'b1000};
        if (a_inf || b_inf) begin
            if (c_inf && (sc != sp)) return {16'h7E00, 4'b1000};
            return {sp, 15'h7C00, 4'b0000};
        end
        if (c_inf) return {c, 4'b0000};
        ma  = (a[14:10] == 0) ? 128'(a[9:0]) : 128'({1'b1, a[9:0]});
        mb  = (b[14:10] == 0) ? 128'(b[9:0]) : 128'({1'b1, b[9:0]});
        mc  = (c[14:10] == 0) ? 128'(c[9:0]) : 128'({1'b1, c[9:0]});
        sha = (a[14:10] == 0) ? 0 : int'(a[14:10]) - 1;
        shb = (b[14:10] == 0) ? 0 : int'(b[14:10]) - 1;
        shc = (c[14:10] == 0) ? 0 : int'(c[14:10]) - 1;
        p = $signed((ma * mb) << (sha + shb));
        if (sp) p = -p;
        z = $signed(mc << (shc + 24));
        if (sc) z = -z;
        s = p + z;
        if (s == 0) begin
            if ((p == 0) && (z == 0) && (sp == sc)) return {sp, 15'h0000, 4'b0000};
            return {(rm == 2'b10), 15'h0000, 4'b0000};
        end
        neg = (s < 0);
        mag = neg ? $unsigned(-s) : $unsigned(s);
        pos = 0;
        for (int i = 0; i < 128; i++) if (mag[i]) pos = i;
        sh   = (pos - 10 > 24) ? pos - 10 : 24;
        tq   = mag >> sh;
        rem  = mag - (tq << sh);
        half = 128'd1 << (sh - 1);
        case (rm)
            2'b00:   inc = 1'b0;
            2'b01:   inc = (rem > half) || ((rem == half) && tq[0]);
            2'b10:   inc = neg && (rem != 0);
            default: inc = !neg && (rem != 0);
        endcase
        tq = tq + 128'(inc);
        if (tq == 128'd2048) begin
            tq = 128'd1024;
            sh = sh + 1;
        end
        inexact = (rem != 0);
        uf      = inexact && (pos < 34);
        if (tq < 128'd1024) return {neg, 5'd0, tq[9:0], 1'b0, 1'b0, uf, inexact};
        field = sh - 23;
        if (field >= 31) begin
            to_inf = (rm == 2'b01) || ((rm == 2'b10) && neg) || ((rm == 2'b11) && !neg);
            return {neg, to_inf ? 15'h7C00 : 15'h7BFF, 4'b0101};
        end
        return {neg, field[4:0], tq[9:0], 1'b0, 1'b0, uf, inexact};
    endfunction

    always_comb begin
        logic [19:0] r;
        r = fma_ref({fma_x[15] ^ fma_negp, fma_x[14:0]},
                    fma_mul ? fma_y : 16'h3C00,
                    fma_add ? {fma_z[15] ^ fma_negz, fma_z[14:0]} : 16'h8000,
                    fma_roundmode);
        fma_result = r[19:4];
        fma_flags  = r[3:0];
    end

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rnd_half();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(7) != 0) h[14:10] = 5'($urandom_range(17, 11));
        return h;
    endfunction

    task automatic wr(input int a, input logic [15:0] v);
        @(negedge clk);
        bus.coef_we   = 1'b1;
        bus.coef_addr = DW'(a);
        bus.coef_data = v;
        @(posedge clk);
        #1 bus.coef_we = 1'b0;
        shadow[a] = v;
    endtask

    // wr_mode 1: write coef[d] in the accept cycle; wr_mode 2: write coef[0]=0 during RUN.
    task automatic eval(input logic [15:0] x, input int d, input logic [1:0] rm,
                        input int wr_mode, input int hold,
                        output logic [15:0] got_r, output logic [3:0] got_f);
        logic [15:0] e_acc, wdat;
        logic [3:0]  e_fl;
        logic [19:0] r;
        logic [15:0] step_x [N_COEF];
        logic [15:0] step_z [N_COEF];
        int dc;
        dc    = (d > N_COEF - 1) ? N_COEF - 1 : d;
        e_acc = shadow[dc];
        e_fl  = 4'b0000;
        for (int k = 0; k < dc; k++) begin
            step_x[k] = e_acc;
            step_z[k] = shadow[dc - 1 - k];
            r = fma_ref(e_acc, x, shadow[dc - 1 - k], rm);
            e_acc = r[19:4];
            e_fl  = e_fl | r[3:0];
        end
        wdat = rnd_half();
        @(negedge clk);
        chk("start_ready_idle", 48'(bus.start_ready), 48'(1'b1));
        bus.start_valid = 1'b1;
        bus.start_x     = x;
        bus.start_deg   = DW'(d);
        bus.start_rm    = rm;
        if (wr_mode == 1) begin
            bus.coef_we   = 1'b1;
            bus.coef_addr = DW'(dc);
            bus.coef_data = wdat;
        end
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        bus.coef_we     = 1'b0;
        if (wr_mode == 1) shadow[dc] = wdat;
        if ((wr_mode == 2) && (dc > 0)) begin
            bus.coef_we   = 1'b1;
            bus.coef_addr = '0;
            bus.coef_data = 16'h0000;
        end
        for (int k = 0; k < dc; k++) begin
            @(negedge clk);
            chk("busy", 48'({bus.out_valid, bus.start_ready}), 48'(2'b00));
            chk("operands", {fma_x, fma_y, fma_z}, {step_x[k], x, step_z[k]});
            chk("controls", 48'({fma_mul, fma_add, fma_negp, fma_negz, fma_roundmode}),
                48'({4'b1100, rm}));
            @(posedge clk);
            #1 bus.coef_we = 1'b0;
        end
        @(negedge clk);
        chk("latency", 48'(bus.out_valid), 48'(1'b1));
        chk("result", 48'(bus.out_result), 48'(e_acc));
        chk("flags", 48'(bus.out_flags), 48'(e_fl));
        chk("quiet_fma", 48'({fma_mul, fma_add, fma_negp, fma_negz, fma_y, fma_z}),
            48'({4'b0000, 16'h3C00, 16'h0000}));
        got_r = bus.out_result;
        got_f = bus.out_flags;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold", 48'({bus.out_valid, bus.start_ready, bus.out_result, bus.out_flags}),
                48'({1'b1, 1'b0, e_acc, e_fl}));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk("ack_idle", 48'({bus.out_valid, bus.start_ready}), 48'(2'b01));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rr;
        logic [3:0]  rf;
        int d, mode;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = 16'h0000;
        bus.start_valid = 1'b0; bus.start_x = 16'h0000; bus.start_deg = '0; bus.start_rm = 2'b00;
        bus.out_ready = 1'b0;
        for (int i = 0; i < N_COEF; i++) shadow[i] = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset_out", 48'({bus.start_ready, bus.out_valid, bus.out_result, bus.out_flags}),
            48'({1'b1, 1'b0, 16'h0000, 4'b0000}));
        chk("reset_fma", 48'({fma_x, fma_y, fma_roundmode}), 48'({16'h0000, 16'h3C00, 2'b01}));
        rst_n = 1'b1;

        // 1 + 2x + 3x^2 at x=2, with a dropped write during RUN and a held result
        wr(0, 16'h3C00); wr(1, 16'h4000); wr(2, 16'h4200);
        eval(16'h4000, 2, 2'b01, 2, 5, rr, rf);
        chk("poly17", 48'({rr, rf}), 48'({16'h4C40, 4'b0000}));
        eval(16'h4000, 2, 2'b01, 0, 0, rr, rf);
        chk("poly17_again", 48'({rr, rf}), 48'({16'h4C40, 4'b0000}));

        // overflow under RNE and RZ
        wr(0, 16'h0000); wr(1, 16'h7BFF);
        eval(16'h4000, 1, 2'b01, 0, 0, rr, rf);
        chk("ovf_rne", 48'({rr, rf}), 48'({16'h7C00, 4'b0101}));
        eval(16'h4000, 1, 2'b00, 0, 0, rr, rf);
        chk("ovf_rz", 48'({rr, rf}), 48'({16'h7BFF, 4'b0101}));

        // degree zero returns c0 without any fma step
        wr(0, 16'hBC00);
        eval(16'h4000, 0, 2'b01, 0, 1, rr, rf);
        chk("deg0", 48'({rr, rf}), 48'({16'hBC00, 4'b0000}));

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N_COEF; i++) wr(i, rnd_half());
            d    = $urandom_range(N_COEF - 1, 0);
            mode = $urandom_range(2, 0);
            eval(rnd_half(), d, 2'($urandom), mode, $urandom_range(2, 0), rr, rf);
        end

        // reset in the middle of a run
        wr(0, 16'h3C00); wr(1, 16'h4000); wr(2, 16'h4200); wr(3, 16'h4400);
        @(negedge clk);
        bus.start_valid = 1'b1; bus.start_x = 16'h4000; bus.start_deg = DW'(3); bus.start_rm = 2'b01;
        @(posedge clk);
        #1 bus.start_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_run", 48'({bus.out_valid, bus.start_ready, bus.out_result, bus.out_flags}),
            48'({1'b0, 1'b1, 16'h0000, 4'b0000}));
        for (int i = 0; i < N_COEF; i++) shadow[i] = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        eval(16'h4000, 2, 2'b01, 0, 0, rr, rf);
        chk("after_reset", 48'({rr, rf}), 48'({16'h0000, 4'b0000}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
